// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory request sequencer: FSM states,
// R/W encoding and the saturating error-counter helper.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int unsigned ERR_CNT_W = 8;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Request buffer: power-of-two depth, registered head, no push-to-pop bypass.
module req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 41
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_en;
  logic             pop_en;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(push_en) - CNT_W'(pop_en);
  end

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_req_sequencer.sv
// Buffers read/write requests and replays them in order onto a single-strobe
// memory port, returning read data (or an out-of-range error) on a response port.
module mem_req_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DinLENGTH  = 32,
  parameter int unsigned MEM_WORDS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Req_Valid,
  output logic                 Req_Ready,
  input  logic                 Req_RW,
  input  logic [WIDTH-1:0]     Req_Addr,
  input  logic [DinLENGTH-1:0] Req_Data,
  output logic [DinLENGTH-1:0] Mem_Din,
  output logic [WIDTH-1:0]     Mem_Addr,
  output logic                 Mem_R_W,
  output logic                 Mem_Valid,
  input  logic [DinLENGTH-1:0] Mem_Dout,
  output logic                 Rsp_Valid,
  input  logic                 Rsp_Ready,
  output logic [DinLENGTH-1:0] Rsp_Data,
  output logic                 Rsp_Err,
  output logic [7:0]           Err_Cnt
);

  localparam int unsigned EW = 1 + WIDTH + DinLENGTH;

  logic [EW-1:0]        fifo_wdata;
  logic [EW-1:0]        fifo_rdata;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 fifo_pop;

  logic                 head_rw;
  logic [WIDTH-1:0]     head_addr;
  logic [DinLENGTH-1:0] head_data;
  logic                 head_in_range;
  logic                 take_head;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mem_addr_q, mem_addr_d;
  logic [DinLENGTH-1:0] mem_din_q, mem_din_d;
  logic                 mem_rw_q, mem_rw_d;
  logic                 mem_valid_q, mem_valid_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DinLENGTH-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [7:0]           err_cnt_q, err_cnt_d;

  assign fifo_wdata = {Req_RW, Req_Addr, Req_Data};
  assign Req_Ready  = ~fifo_full;

  req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (EW)
  ) u_req_fifo (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .push_i  (Req_Valid),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign head_rw       = fifo_rdata[EW-1];
  assign head_addr     = fifo_rdata[DinLENGTH +: WIDTH];
  assign head_data     = fifo_rdata[DinLENGTH-1:0];
  assign head_in_range = (32'(head_addr) < 32'(MEM_WORDS));

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_rw_d    = mem_rw_q;
    mem_valid_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;
    fifo_pop    = 1'b0;
    take_head   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) take_head = 1'b1;
      end
      ISSUE: begin
        if (mem_rw_q != RW_WRITE)  state_d = CAPTURE;
        else if (!fifo_empty)      take_head = 1'b1;
        else                       state_d = IDLE;
      end
      CAPTURE: begin
        rsp_data_d  = Mem_Dout;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (Rsp_Ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Dispatch of the popped head entry, shared by IDLE and write streaming.
    if (take_head) begin
      fifo_pop = 1'b1;
      if (head_in_range) begin
        mem_addr_d  = head_addr;
        mem_din_d   = head_data;
        mem_rw_d    = head_rw;
        mem_valid_d = 1'b1;
        state_d     = ISSUE;
      end else begin
        err_cnt_d = sat_inc(err_cnt_q);
        if (head_rw == RW_READ) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_rw_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_rw_q    <= mem_rw_d;
      mem_valid_q <= mem_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign Mem_Addr  = mem_addr_q;
  assign Mem_Din   = mem_din_q;
  assign Mem_R_W   = mem_rw_q;
  assign Mem_Valid = mem_valid_q;
  assign Rsp_Valid = rsp_valid_q;
  assign Rsp_Data  = rsp_data_q;
  assign Rsp_Err   = rsp_err_q;
  assign Err_Cnt   = err_cnt_q;

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Directed bench for mem_req_sequencer with a registered-read memory model.
module tb_mem_req_sequencer;

  logic        Clk;
  logic        Reset_n;
  logic        Req_Valid;
  logic        Req_Ready;
  logic        Req_RW;
  logic [7:0]  Req_Addr;
  logic [31:0] Req_Data;
  logic [31:0] Mem_Din;
  logic [7:0]  Mem_Addr;
  logic        Mem_R_W;
  logic        Mem_Valid;
  logic [31:0] Mem_Dout;
  logic        Rsp_Valid;
  logic        Rsp_Ready;
  logic [31:0] Rsp_Data;
  logic        Rsp_Err;
  logic [7:0]  Err_Cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] din;
    int          cyc;
  } pulse_t;
  pulse_t mon_q[$];

  typedef struct {
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] data;
    int          pulses;
    logic        rsp_err;
    logic [31:0] rsp_data;
    int          err_cnt;
  } vec_t;
  vec_t vecs[11];

  logic [31:0] mem_model [8];

  mem_req_sequencer #(
    .WIDTH      (8),
    .DinLENGTH  (32),
    .MEM_WORDS  (8),
    .FIFO_DEPTH (4)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Req_Valid (Req_Valid),
    .Req_Ready (Req_Ready),
    .Req_RW    (Req_RW),
    .Req_Addr  (Req_Addr),
    .Req_Data  (Req_Data),
    .Mem_Din   (Mem_Din),
    .Mem_Addr  (Mem_Addr),
    .Mem_R_W   (Mem_R_W),
    .Mem_Valid (Mem_Valid),
    .Mem_Dout  (Mem_Dout),
    .Rsp_Valid (Rsp_Valid),
    .Rsp_Ready (Rsp_Ready),
    .Rsp_Data  (Rsp_Data),
    .Rsp_Err   (Rsp_Err),
    .Err_Cnt   (Err_Cnt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Memory model plus strobe monitor; Mem_Dout updates on the sampling edge.
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (Mem_Valid) begin
      mon_q.push_back('{Mem_R_W, Mem_Addr, Mem_Din, cyc});
      if (Mem_R_W) mem_model[Mem_Addr[2:0]] <= Mem_Din;
      else         Mem_Dout <= mem_model[Mem_Addr[2:0]];
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic rw, input logic [7:0] addr, input logic [31:0] data);
    int g = 0;
    Req_Valid = 1'b1;
    Req_RW    = rw;
    Req_Addr  = addr;
    Req_Data  = data;
    while (!Req_Ready && g < 50) begin
      tick();
      g++;
    end
    tick();
    Req_Valid = 1'b0;
  endtask

  task automatic wait_rsp(output int k);
    k = 0;
    while (!Rsp_Valid && k < 20) begin
      tick();
      k++;
    end
  endtask

  task automatic release_rsp();
    Rsp_Ready = 1'b1;
    tick();
    Rsp_Ready = 1'b0;
  endtask

  initial begin
    int k;
    logic [31:0] got[$];
    logic        rsp_seen;

    vecs[0]  = '{1'b1, 8'd5,   32'h1111_2222, 1, 1'b0, 32'h0,         0};
    vecs[1]  = '{1'b0, 8'd5,   32'h0,         1, 1'b0, 32'h1111_2222, 0};
    vecs[2]  = '{1'b1, 8'd7,   32'hCAFE_F00D, 1, 1'b0, 32'h0,         0};
    vecs[3]  = '{1'b0, 8'd7,   32'h0,         1, 1'b0, 32'hCAFE_F00D, 0};
    vecs[4]  = '{1'b0, 8'd0,   32'h0,         1, 1'b0, 32'h0000_0100, 0};
    vecs[5]  = '{1'b0, 8'd9,   32'h0,         0, 1'b1, 32'h0,         1};
    vecs[6]  = '{1'b1, 8'd12,  32'h1234_5678, 0, 1'b0, 32'h0,         2};
    vecs[7]  = '{1'b0, 8'd8,   32'h0,         0, 1'b1, 32'h0,         3};
    vecs[8]  = '{1'b0, 8'd3,   32'h0,         1, 1'b0, 32'h0000_0103, 3};
    vecs[9]  = '{1'b1, 8'd255, 32'hFFFF_0000, 0, 1'b0, 32'h0,         4};
    vecs[10] = '{1'b0, 8'd2,   32'h0,         1, 1'b0, 32'h0000_0102, 4};

    Reset_n   = 1'b0;
    Req_Valid = 1'b0;
    Req_RW    = 1'b0;
    Req_Addr  = '0;
    Req_Data  = '0;
    Rsp_Ready = 1'b0;
    Mem_Dout  = '0;
    for (int i = 0; i < 8; i++) mem_model[i] = '0;

    // Reset values
    #12;
    chk("rst_mem_valid", 32'(Mem_Valid), 0);
    chk("rst_mem_addr",  32'(Mem_Addr),  0);
    chk("rst_rsp_valid", 32'(Rsp_Valid), 0);
    chk("rst_rsp_data",  Rsp_Data,       0);
    chk("rst_err_cnt",   32'(Err_Cnt),   0);
    Reset_n = 1'b1;
    tick();
    chk("rst_req_ready", 32'(Req_Ready), 1);

    // Write then read address 3
    mon_q.delete();
    push_req(1'b1, 8'd3, 32'hDEAD_BEEF);
    push_req(1'b0, 8'd3, 32'h0);
    wait_rsp(k);
    chk("wr_rd_latency", 32'(k), 3);
    chk("wr_rd_data", Rsp_Data, 32'hDEAD_BEEF);
    chk("wr_rd_err", 32'(Rsp_Err), 0);
    chk("wr_rd_pulses", 32'(mon_q.size()), 2);
    if (mon_q.size() >= 2) begin
      chk("wr_pulse_rw",   32'(mon_q[0].rw),   1);
      chk("wr_pulse_addr", 32'(mon_q[0].addr), 3);
      chk("wr_pulse_din",  mon_q[0].din,       32'hDEAD_BEEF);
      chk("rd_pulse_rw",   32'(mon_q[1].rw),   0);
      chk("rd_pulse_addr", 32'(mon_q[1].addr), 3);
    end
    release_rsp();
    chk("wr_rd_rsp_clear", 32'(Rsp_Valid), 0);

    // Back-to-back writes, Req_Valid held high
    mon_q.delete();
    Req_Valid = 1'b1;
    Req_RW    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Req_Addr = 8'(i);
      Req_Data = 32'h100 + 32'(i);
      tick();
    end
    Req_Valid = 1'b0;
    repeat (4) tick();
    chk("b2b_pulses", 32'(mon_q.size()), 4);
    if (mon_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("b2b_addr%0d", i), 32'(mon_q[i].addr), 32'(i));
        chk($sformatf("b2b_cyc%0d", i), 32'(mon_q[i].cyc - mon_q[0].cyc), 32'(i));
      end
    end

    // Table of single transactions, including range boundaries
    for (int v = 0; v < 11; v++) begin
      mon_q.delete();
      push_req(vecs[v].rw, vecs[v].addr, vecs[v].data);
      if (vecs[v].rw == 1'b0) begin
        wait_rsp(k);
        chk($sformatf("v%0d_rsp_valid", v), 32'(Rsp_Valid), 1);
        chk($sformatf("v%0d_rsp_data", v), Rsp_Data, vecs[v].rsp_data);
        chk($sformatf("v%0d_rsp_err", v), 32'(Rsp_Err), 32'(vecs[v].rsp_err));
        release_rsp();
      end else begin
        repeat (4) tick();
      end
      chk($sformatf("v%0d_pulses", v), 32'(mon_q.size()), 32'(vecs[v].pulses));
      chk($sformatf("v%0d_err_cnt", v), 32'(Err_Cnt), 32'(vecs[v].err_cnt));
    end

    // Backpressure: response held, FIFO fills, then drains in order
    Req_Valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin Req_RW = 1'b0; Req_Addr = 8'd5; Req_Data = 32'h0;  end
        1: begin Req_RW = 1'b1; Req_Addr = 8'd6; Req_Data = 32'h66; end
        2: begin Req_RW = 1'b0; Req_Addr = 8'd6; Req_Data = 32'h0;  end
        3: begin Req_RW = 1'b0; Req_Addr = 8'd0; Req_Data = 32'h0;  end
        default: begin Req_RW = 1'b0; Req_Addr = 8'd7; Req_Data = 32'h0; end
      endcase
      chk($sformatf("bp_ready_before%0d", i), 32'(Req_Ready), 1);
      tick();
    end
    Req_Valid = 1'b0;
    chk("bp_ready_full", 32'(Req_Ready), 0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold_valid%0d", i), 32'(Rsp_Valid), 1);
      chk($sformatf("bp_hold_data%0d", i), Rsp_Data, 32'h1111_2222);
      tick();
    end
    Rsp_Ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (Rsp_Valid) got.push_back(Rsp_Data);
      tick();
    end
    Rsp_Ready = 1'b0;
    chk("bp_rsp_count", 32'(got.size()), 4);
    if (got.size() == 4) begin
      chk("bp_rsp0", got[0], 32'h1111_2222);
      chk("bp_rsp1", got[1], 32'h66);
      chk("bp_rsp2", got[2], 32'h100);
      chk("bp_rsp3", got[3], 32'hCAFE_F00D);
    end
    chk("bp_ready_back", 32'(Req_Ready), 1);

    // Error counter saturation with streamed out-of-range writes
    Req_Valid = 1'b1;
    Req_RW    = 1'b1;
    Req_Addr  = 8'd200;
    repeat (10) tick();
    Req_Valid = 1'b0;
    repeat (3) tick();
    chk("err_cnt_14", 32'(Err_Cnt), 14);
    Req_Valid = 1'b1;
    repeat (260) tick();
    Req_Valid = 1'b0;
    repeat (3) tick();
    chk("err_cnt_sat", 32'(Err_Cnt), 255);

    // Reset in CAPTURE with two requests queued
    Req_Valid = 1'b1;
    Req_RW    = 1'b0;
    Req_Addr  = 8'd5;
    tick();
    Req_Addr  = 8'd6;
    tick();
    Req_Addr  = 8'd7;
    tick();
    Req_Valid = 1'b0;
    chk("pre_rst_mem_addr", 32'(Mem_Addr), 5);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_mem_addr",  32'(Mem_Addr),  0);
    chk("mid_rst_mem_rw",    32'(Mem_R_W),   0);
    chk("mid_rst_mem_valid", 32'(Mem_Valid), 0);
    chk("mid_rst_rsp_valid", 32'(Rsp_Valid), 0);
    chk("mid_rst_err_cnt",   32'(Err_Cnt),   0);
    chk("mid_rst_req_ready", 32'(Req_Ready), 1);
    repeat (2) tick();
    mon_q.delete();
    Reset_n  = 1'b1;
    rsp_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (Rsp_Valid) rsp_seen = 1'b1;
    end
    chk("post_rst_no_rsp", 32'(rsp_seen), 0);
    chk("post_rst_no_pulse", 32'(mon_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
